// File: rtl/cut_data_window.sv
// Streaming 2-D window cropper: forwards beats inside a row/column-chunk window
// through a 2-entry skid buffer with a last-of-window sideband bit.

module cut_data_window_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_main_in,
  input  logic         ld_main_skid,
  input  logic         ld_skid,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] skid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_skid)    dout <= skid_q;
      else if (ld_main_in) dout <= din;
      if (ld_skid) skid_q <= din;
    end
  end
endmodule

module cut_data_window #(
  parameter int IN_WIDTH     = 32,
  parameter int IN_Y         = 4,
  parameter int IN_X         = 8,
  parameter int UNROLL_IN_X  = 2,
  parameter int KEEP_Y_START = 0,
  parameter int KEEP_Y_NUM   = 1,
  parameter int KEEP_X_START = 0,
  parameter int KEEP_X_NUM   = IN_X / UNROLL_IN_X
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in [UNROLL_IN_X],
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [IN_WIDTH-1:0] data_out [UNROLL_IN_X],
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                data_out_last,
  output logic                frame_done
);
  localparam int ITER_X = IN_X / UNROLL_IN_X;
  localparam int XW     = (ITER_X > 1) ? $clog2(ITER_X) : 1;
  localparam int YW     = (IN_Y > 1) ? $clog2(IN_Y) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(ITER_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IN_Y - 1);
  localparam logic [XW-1:0] X_LO  = XW'(KEEP_X_START);
  localparam logic [XW-1:0] X_HI  = XW'(KEEP_X_START + KEEP_X_NUM - 1);
  localparam logic [YW-1:0] Y_LO  = YW'(KEEP_Y_START);
  localparam logic [YW-1:0] Y_HI  = YW'(KEEP_Y_START + KEEP_Y_NUM - 1);

  if (UNROLL_IN_X < 1 || IN_X % UNROLL_IN_X != 0) begin : g_chk_unroll
    $error("cut_data_window: IN_X must be a multiple of UNROLL_IN_X");
  end
  if (KEEP_Y_START < 0 || KEEP_Y_NUM < 1 || KEEP_Y_START + KEEP_Y_NUM > IN_Y) begin : g_chk_y
    $error("cut_data_window: row window out of range");
  end
  if (KEEP_X_START < 0 || KEEP_X_NUM < 1 || KEEP_X_START + KEEP_X_NUM > ITER_X) begin : g_chk_x
    $error("cut_data_window: column window out of range");
  end

  // position counters
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_end, y_end, in_hs;

  assign x_end = (x == X_MAX);
  assign y_end = (y == Y_MAX);
  assign in_hs = data_in_valid && data_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_hs && x_end && y_end;
      if (in_hs) begin
        if (x_end) begin
          x <= '0;
          y <= y_end ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Window bounds that coincide with the counter range are folded to constants.
  logic x_ge, x_le, y_ge, y_le, keep, last_keep;

  if (KEEP_X_START == 0) begin : g_xlo_any
    assign x_ge = 1'b1;
  end else begin : g_xlo_cmp
    assign x_ge = (x >= X_LO);
  end
  if (KEEP_X_START + KEEP_X_NUM == ITER_X) begin : g_xhi_any
    assign x_le = 1'b1;
  end else begin : g_xhi_cmp
    assign x_le = (x <= X_HI);
  end
  if (KEEP_Y_START == 0) begin : g_ylo_any
    assign y_ge = 1'b1;
  end else begin : g_ylo_cmp
    assign y_ge = (y >= Y_LO);
  end
  if (KEEP_Y_START + KEEP_Y_NUM == IN_Y) begin : g_yhi_any
    assign y_le = 1'b1;
  end else begin : g_yhi_cmp
    assign y_le = (y <= Y_HI);
  end

  assign keep      = x_ge && x_le && y_ge && y_le;
  assign last_keep = keep && (x == X_HI) && (y == Y_HI);

  // skid buffer: main entry drives the outputs, skid entry absorbs one stall
  logic skid_v, skid_last, buf_ready, wr, pop;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign buf_ready     = !skid_v;
  assign data_in_ready = !keep || buf_ready;
  assign wr            = in_hs && keep;
  assign pop           = data_out_valid && data_out_ready;
  assign ld_main_skid  = skid_v && pop;
  assign ld_main_in    = !skid_v && (!data_out_valid || pop) && wr;
  assign ld_skid       = !skid_v && data_out_valid && !pop && wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      skid_v         <= 1'b0;
      skid_last      <= 1'b0;
    end else if (skid_v) begin
      if (pop) begin
        data_out_last <= skid_last;
        skid_v        <= 1'b0;
      end
    end else if (!data_out_valid || pop) begin
      data_out_valid <= wr;
      if (wr) data_out_last <= last_keep;
    end else if (wr) begin
      skid_v    <= 1'b1;
      skid_last <= last_keep;
    end
  end

  for (genvar i = 0; i < UNROLL_IN_X; i++) begin : g_lane
    cut_data_window_lane #(.W(IN_WIDTH)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .ld_main_in   (ld_main_in),
      .ld_main_skid (ld_main_skid),
      .ld_skid      (ld_skid),
      .din          (data_in[i]),
      .dout         (data_out[i])
    );
  end
endmodule

// File: tb/tb_cut_data_window.sv
// Bench for cut_data_window: three instances (crop window, default window,
// single-beat frame) checked against a frame-index reference model.

module tb_cut_data_window;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] a_din [2], a_dout [2];
  logic a_iv = 0, a_ir, a_ov, a_or = 1, a_last, a_fd;
  logic [W-1:0] b_din [2], b_dout [2];
  logic b_iv = 0, b_ir, b_ov, b_or = 1, b_last, b_fd;
  logic [W-1:0] c_din [4], c_dout [4];
  logic c_iv = 0, c_ir, c_ov, c_or = 1, c_last, c_fd;

  cut_data_window #(.IN_WIDTH(W), .IN_Y(4), .IN_X(8), .UNROLL_IN_X(2),
    .KEEP_Y_START(1), .KEEP_Y_NUM(2), .KEEP_X_START(1), .KEEP_X_NUM(2)) u_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_iv), .data_in_ready(a_ir),
    .data_out(a_dout), .data_out_valid(a_ov), .data_out_ready(a_or),
    .data_out_last(a_last), .frame_done(a_fd));

  cut_data_window #(.IN_WIDTH(W)) u_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_iv), .data_in_ready(b_ir),
    .data_out(b_dout), .data_out_valid(b_ov), .data_out_ready(b_or),
    .data_out_last(b_last), .frame_done(b_fd));

  cut_data_window #(.IN_WIDTH(W), .IN_Y(1), .IN_X(4), .UNROLL_IN_X(4)) u_c (
    .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_iv), .data_in_ready(c_ir),
    .data_out(c_dout), .data_out_valid(c_ov), .data_out_ready(c_or),
    .data_out_last(c_last), .frame_done(c_fd));

  // reference model state: in-frame beat index and expected output queues
  logic [64:0]  a_q [$], b_q [$];
  logic [128:0] c_q [$];
  int a_n = 0, b_n = 0;
  bit a_fd_exp = 0, b_fd_exp = 0, c_fd_exp = 0;
  int a_log [$];
  int b_fd_cnt = 0, b_out_cnt = 0, c_fd_cnt = 0, c_out_cnt = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {is_last_of_window, is_kept} for beat n of a frame
  function automatic logic [1:0] kl(int n, int ix, int ys, int yn, int xs, int xn);
    int  r = n / ix;
    int  c = n % ix;
    logic k = (r >= ys) && (r < ys + yn) && (c >= xs) && (c < xs + xn);
    return {k && (r == ys + yn - 1) && (c == xs + xn - 1), k};
  endfunction

  task automatic tick();
    logic [1:0] k;
    logic [64:0] e2;
    logic [128:0] e4;
    @(negedge clk);
    if (rst) begin
      a_q.delete(); b_q.delete(); c_q.delete();
      a_n = 0; b_n = 0;
      a_fd_exp = 0; b_fd_exp = 0; c_fd_exp = 0;
    end else begin
      chk("a_frame_done", a_fd, a_fd_exp);
      chk("b_frame_done", b_fd, b_fd_exp);
      chk("c_frame_done", c_fd, c_fd_exp);
      a_fd_exp = 0; b_fd_exp = 0; c_fd_exp = 0;
      if (b_fd) b_fd_cnt++;
      if (c_fd) c_fd_cnt++;
      if (a_ov && a_or) begin
        if (a_q.size() == 0) chk("a_spurious_out", 1, 0);
        else begin
          e2 = a_q.pop_front();
          chk("a_out", {a_last, a_dout[1], a_dout[0]}, e2);
        end
        a_log.push_back(int'(a_dout[0]));
      end
      if (b_ov && b_or) begin
        b_out_cnt++;
        if (b_q.size() == 0) chk("b_spurious_out", 1, 0);
        else begin
          e2 = b_q.pop_front();
          chk("b_out", {b_last, b_dout[1], b_dout[0]}, e2);
        end
      end
      if (c_ov && c_or) begin
        c_out_cnt++;
        if (c_q.size() == 0) chk("c_spurious_out", 1, 0);
        else begin
          e4 = c_q.pop_front();
          chk("c_out", {c_last, c_dout[3], c_dout[2], c_dout[1], c_dout[0]}, e4);
        end
      end
      if (a_iv && a_ir) begin
        k = kl(a_n, 4, 1, 2, 1, 2);
        if (k[0]) a_q.push_back({k[1], a_din[1], a_din[0]});
        a_fd_exp = (a_n == 15);
        a_n = (a_n + 1) % 16;
      end
      if (b_iv && b_ir) begin
        k = kl(b_n, 4, 0, 1, 0, 4);
        if (k[0]) b_q.push_back({k[1], b_din[1], b_din[0]});
        b_fd_exp = (b_n == 15);
        b_n = (b_n + 1) % 16;
      end
      if (c_iv && c_ir) begin
        k = kl(0, 1, 0, 1, 0, 1);
        if (k[0]) c_q.push_back({k[1], c_din[3], c_din[2], c_din[1], c_din[0]});
        c_fd_exp = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input int v0, input int v1);
    bit acc = 0;
    a_iv = 1; a_din[0] = W'(v0); a_din[1] = W'(v1);
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = a_ir;
      tick();
    end
    a_iv = 0;
    if (!acc) chk("a_beat_timeout", 0, 1);
  endtask

  task automatic a_log_chk(input string tag, input int e0, e1, e2, e3);
    int exp4 [4];
    exp4 = '{e0, e1, e2, e3};
    chk({tag, "_count"}, a_log.size(), 4);
    for (int i = 0; i < 4 && i < a_log.size(); i++) chk(tag, a_log[i], exp4[i]);
    a_log.delete();
  endtask

  initial begin
    int b_sent;
    bit acc;
    for (int i = 0; i < 2; i++) begin a_din[i] = '0; b_din[i] = '0; end
    for (int i = 0; i < 4; i++) c_din[i] = '0;

    // reset state
    rst = 1; tick(); tick();
    rst = 0;
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_a_fd", a_fd, 0);
    chk("rst_a_data", {a_dout[1], a_dout[0]}, 0);
    chk("rst_a_ready", a_ir, 1);
    chk("rst_b_ready", b_ir, 1);
    chk("rst_c_valid", c_ov, 0);

    // crop window, no backpressure
    a_or = 1;
    for (int n = 0; n < 16; n++) a_beat(n, n + 100);
    repeat (3) tick();
    a_log_chk("t1_a_lane0", 5, 6, 9, 10);
    chk("t1_a_q_empty", a_q.size(), 0);

    // crop window, output stalled: 5 and 6 fill the buffer, 9 must stall
    a_or = 0;
    for (int n = 0; n < 9; n++) begin
      chk("t2_a_ready_pre", a_ir, 1);
      a_beat(n, n + 100);
    end
    a_iv = 1; a_din[0] = 9; a_din[1] = 109;
    chk("t2_a_ready_stall", a_ir, 0);
    repeat (3) tick();
    chk("t2_a_ready_hold", a_ir, 0);
    chk("t2_a_data_hold", a_dout[0], 5);
    a_or = 1;
    for (int n = 9; n < 16; n++) a_beat(n, n + 100);
    repeat (3) tick();
    a_log_chk("t2_a_lane0", 5, 6, 9, 10);

    // reset mid-frame with 5 and 6 buffered
    a_or = 0;
    for (int n = 0; n < 7; n++) a_beat(200 + n, 300 + n);
    rst = 1; tick();
    rst = 0;
    chk("t4_a_valid_after_rst", a_ov, 0);
    a_log.delete();
    a_or = 1;
    for (int n = 0; n < 16; n++) a_beat(1000 + n, 2000 + n);
    repeat (3) tick();
    a_log_chk("t4_a_lane0", 1005, 1006, 1009, 1010);

    // default window, random valid/ready over 20 frames
    b_sent = 0;
    for (int cyc = 0; cyc < 5000 && b_sent < 320; cyc++) begin
      b_iv = 1'($urandom_range(0, 1));
      b_or = 1'($urandom_range(0, 1));
      b_din[0] = $urandom; b_din[1] = $urandom;
      acc = b_iv && b_ir;
      tick();
      if (acc) b_sent++;
    end
    b_iv = 0; b_or = 1;
    repeat (4) tick();
    chk("t3_b_sent", b_sent, 320);
    chk("t3_b_q_empty", b_q.size(), 0);
    chk("t3_b_out_cnt", b_out_cnt, 80);
    chk("t3_b_fd_cnt", b_fd_cnt, 20);

    // single-beat frames, continuous throughput
    c_iv = 1; c_or = 1;
    for (int n = 0; n < 8; n++) begin
      for (int l = 0; l < 4; l++) c_din[l] = $urandom;
      chk("t5_c_ready", c_ir, 1);
      tick();
      chk("t5_c_valid", c_ov, 1);
      chk("t5_c_last", c_last, 1);
    end
    c_iv = 0;
    repeat (3) tick();
    chk("t5_c_out_cnt", c_out_cnt, 8);
    chk("t5_c_fd_cnt", c_fd_cnt, 8);
    chk("t5_c_q_empty", c_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cut_data_window.md
Name: cut_data_window

Overview:
- Streaming 2-D window cropper for unrolled tensor streams.
- Input is frames of IN_Y rows × IN_X elements, delivered UNROLL_IN_X elements per beat in row-major order.
- Forwards only the beats inside a parametrised row/column-chunk window; all other beats are consumed and discarded.
- Sits between compute stages wherever a tensor sub-region must be extracted, e.g. a class token or a patch crop. Output is registered through an internal 2-entry skid buffer and tagged with a last-of-window flag.

Parameters:
- IN_WIDTH, 32, bit width of each element.
- IN_Y, 4, rows per frame.
- IN_X, 8, elements per row.
- UNROLL_IN_X, 2, elements per beat. IN_X % UNROLL_IN_X must equal 0.
- KEEP_Y_START, 0, first kept row.
- KEEP_Y_NUM, 1, number of kept rows. KEEP_Y_START + KEEP_Y_NUM <= IN_Y, and KEEP_Y_NUM >= 1.
- KEEP_X_START, 0, first kept column chunk, in beats.
- KEEP_X_NUM, ITER_X, number of kept chunks per row, where ITER_X = IN_X / UNROLL_IN_X. KEEP_X_START + KEEP_X_NUM <= ITER_X, and KEEP_X_NUM >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- data_in  in  [IN_WIDTH-1:0] × UNROLL_IN_X (unpacked)  input beat.
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
- data_out  out  [IN_WIDTH-1:0] × UNROLL_IN_X (unpacked)  output beat.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.
- data_out_last  out  1  high on the final kept beat of a frame; qualified by data_out_valid.
- frame_done  out  1  one-cycle pulse when the last input beat of a frame is accepted.

Behaviour:
- Illegal parameter combinations cause an elaboration-time error via $error in a generate check.

Position counters:
- x counts 0..ITER_X-1; y counts 0..IN_Y-1.
- Counter width is max(1, $clog2(N)), so degenerate sizes of 1 are legal.
- Counters advance only on input handshake (data_in_valid && data_in_ready):
  - x increments.
  - At x == ITER_X-1, x wraps to 0 and y increments.
  - At y == IN_Y-1 and x == ITER_X-1, both wrap to 0.

Keep decision (combinational on the current counters):
- keep = (y ∈ [KEEP_Y_START, KEEP_Y_START+KEEP_Y_NUM)) && (x ∈ [KEEP_X_START, KEEP_X_START+KEEP_X_NUM)).
- last_keep = keep && y == KEEP_Y_START+KEEP_Y_NUM-1 && x == KEEP_X_START+KEEP_X_NUM-1.

Input handshake:
- data_in_ready = !keep || buf_ready.
- buf_ready is the skid buffer's registered not-full flag. There is no combinational path from data_out_ready to data_in_ready.
- Dropped beats (!keep) are accepted every cycle data_in_valid is high, regardless of output backpressure.
- A kept beat is written into the buffer together with last_keep as a sideband bit.

Skid buffer (2 entries, main plus skid):
- Outputs data_out, data_out_valid and data_out_last are driven directly from registers.
- Latency is 1 cycle from input handshake to data_out_valid when the buffer is empty.
- Sustains 1 beat per cycle when data_out_ready is held high.
- buf_ready deasserts only when the skid entry holds data.
- Ordering is strictly preserved; no beat is lost or duplicated under any ready/valid interleaving.
- data_out and data_out_last hold stable while data_out_valid && !data_out_ready.

frame_done:
- Registered.
- Asserted in the cycle after the handshake at y == IN_Y-1 and x == ITER_X-1.

Reset values:
- x = 0, y = 0.
- Buffer empty.
- data_out_valid = 0, data_out_last = 0, frame_done = 0.
- data_out = 0.
- buf_ready = 1 in the first cycle after reset.

Boundary conditions:
- Reset mid-frame: counters return to 0 and buffered beats are discarded. The next accepted beat is treated as the frame's (0,0).
- Back-to-back frames: no bubble at the frame boundary. Frame n+1 beat (0,0) may be accepted in the cycle after frame n's last beat.
- Full window (all KEEP_* spanning the frame): pass-through. data_out_last is on the final beat; data_in_ready follows buf_ready only.
- Single-beat window (KEEP_Y_NUM = KEEP_X_NUM = 1): every kept beat has data_out_last = 1.
- Output stalled and next input beat dropped: the beat is accepted, counters advance, and the buffer is unchanged.

Test Plan:
- Defaults with KEEP_Y_START=1, KEEP_Y_NUM=2, KEEP_X_START=1, KEEP_X_NUM=2; beat n has lane0 = n, lane1 = n+100; 16 beats streamed, data_out_ready = 1 -> outputs are lane0 = 5, 6, 9, 10, with data_out_last only on 10, and frame_done pulses once the cycle after beat 15.
- Same config, data_out_ready = 0 throughout -> beats 0–6 accepted (5 and 6 buffered), data_in_ready = 0 at beat 9; raising ready drains 5, 6, then 9, 10, with no loss.
- Random valid/ready toggling (50%) over 20 frames with the default window (KEEP_Y_NUM=1, full row) -> output equals beats 0–3 of each frame, in order; data_out_last on each lane0 = 3 (frame-relative); 20 frame_done pulses.
- Reset asserted after beat 6 of a frame with the buffer holding 5 and 6 -> data_out_valid = 0 next cycle; a fresh 16-beat frame yields exactly 5, 6, 9, 10 (new values).
- IN_Y=1, IN_X=UNROLL_IN_X=4 (ITER_X=1), full window -> every beat is passed with data_out_last = 1 and frame_done pulsing per beat; continuous 1 beat/cycle throughput.
- Illegal parameters (IN_X=6, UNROLL_IN_X=4) -> elaboration fails with $error.
